// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: branch/jump resolution from ALU flags plus a 2-entry skid slot.
// Optional macro BRANCH_STATS_EN adds br_count / br_taken_count statistics outputs.
module ex_mem_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            carry,
    input  logic            zero,
    input  logic            negative,
    input  logic            overflow,
    input  logic            branch,
    input  logic            jump,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] write_data,
    input  logic [RD_W-1:0] rd,
    input  logic            reg_write,
    input  logic            mem_write,
    input  logic [1:0]      result_src,
    input  logic            flush,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     br_count,
    output logic [31:0]     br_taken_count,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_write_data,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_write,
    output logic [1:0]      out_result_src,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam int PW = 3 * XLEN + RD_W + 4;

    state_t          state_q, state_d;
    logic [PW-1:0]   in_pkt, main_q, main_d, skid_q, skid_d;
    logic            accept, deliver, cond, taken;

    assign in_pkt  = {alu_result, write_data, pc_plus4, rd, reg_write, mem_write, result_src};
    assign accept  = in_valid & in_ready & ~flush;
    assign out_valid = (state_q != EMPTY);
    assign deliver = out_valid & out_ready;

    assign {out_alu_result, out_write_data, out_pc_plus4, out_rd,
            out_reg_write, out_mem_write, out_result_src} = main_q;

    // ALU computed A-B; carry set means no borrow, i.e. A >= B unsigned.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = zero;
            3'b001:  cond = ~zero;
            3'b100:  cond = negative ^ overflow;
            3'b101:  cond = ~(negative ^ overflow);
            3'b110:  cond = ~carry;
            3'b111:  cond = carry;
            default: cond = 1'b0;
        endcase
    end

    assign taken = jump | (branch & cond);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_pkt;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_d = in_pkt;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_pkt;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= EMPTY;
            in_ready       <= 1'b1;
            main_q         <= '0;
            skid_q         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state_q        <= state_d;
            in_ready       <= (state_d != TWO);
            main_q         <= main_d;
            skid_q         <= skid_d;
            redirect_valid <= accept & taken;
            if (accept && taken) begin
                redirect_pc <= pc_target;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Counters deliberately ignore flush; they only track accepted control flow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else begin
            if (accept && (branch || jump)) begin
                br_count <= br_count + 32'd1;
            end
            if (accept && taken) begin
                br_taken_count <= br_taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: branch-condition table, directed skid/flush/reset
// sequences and a randomized run against a queue-based reference model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] alu_result;
    logic        carry, zero, negative, overflow;
    logic        branch, jump;
    logic [2:0]  funct3;
    logic [31:0] pc_target, pc_plus4, write_data;
    logic [4:0]  rd;
    logic        reg_write, mem_write;
    logic [1:0]  result_src;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_alu_result, out_write_data, out_pc_plus4;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_write;
    logic [1:0]  out_result_src;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, br_taken_count;
`endif

    ex_mem_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .carry(carry), .zero(zero),
        .negative(negative), .overflow(overflow),
        .branch(branch), .jump(jump), .funct3(funct3),
        .pc_target(pc_target), .pc_plus4(pc_plus4), .write_data(write_data),
        .rd(rd), .reg_write(reg_write), .mem_write(mem_write),
        .result_src(result_src), .flush(flush),
`ifdef BRANCH_STATS_EN
        .br_count(br_count), .br_taken_count(br_taken_count),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_write_data(out_write_data),
        .out_pc_plus4(out_pc_plus4), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
        .out_result_src(out_result_src),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid, branch, jump;
        logic [2:0]  funct3;
        logic [31:0] a, b, pc_target, pc_plus4;
        logic        out_ready, flush;
    } stim_t;

    typedef struct {
        logic [31:0] alu, wd, pc4;
        logic [9:0]  ctrl;
    } pkt_t;

    typedef struct {
        logic        branch, jump;
        logic [2:0]  funct3;
        logic [31:0] a, b;
        logic        exp_taken;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    stim_t  cur;
    pkt_t   q[$];
    logic   m_in_ready;
    logic   m_rv;
    logic [31:0] m_rpc, m_brc, m_brt;
    vec_t   vecs[13];

    function automatic stim_t mkStim(logic iv, logic br, logic jp, logic [2:0] f3,
                                     logic [31:0] a, logic [31:0] b, logic [31:0] tgt,
                                     logic [31:0] pc4, logic ordy, logic fl);
        stim_t s;
        s.in_valid = iv; s.branch = br; s.jump = jp; s.funct3 = f3;
        s.a = a; s.b = b; s.pc_target = tgt; s.pc_plus4 = pc4;
        s.out_ready = ordy; s.flush = fl;
        return s;
    endfunction

    // Control fields are derived from the operands so every packet is distinguishable.
    function automatic logic [9:0] ctrlOf(stim_t s);
        return {s.a[4:0], s.b[0], s.a[2], s.b[2:1]};
    endfunction

    // Reference branch decision from the operands themselves, not the flags.
    function automatic logic refTaken(stim_t s);
        if (s.jump) return 1'b1;
        if (!s.branch) return 1'b0;
        case (s.funct3)
            3'b000:  return s.a == s.b;
            3'b001:  return s.a != s.b;
            3'b100:  return $signed(s.a) < $signed(s.b);
            3'b101:  return $signed(s.a) >= $signed(s.b);
            3'b110:  return s.a < s.b;
            3'b111:  return s.a >= s.b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic applyStimulus(input stim_t s);
        logic [31:0] d;
        cur = s;
        d = s.a - s.b;
        in_valid   = s.in_valid;
        branch     = s.branch;
        jump       = s.jump;
        funct3     = s.funct3;
        alu_result = d;
        carry      = (s.a >= s.b);
        zero       = (d == 32'd0);
        negative   = d[31];
        overflow   = (s.a[31] != s.b[31]) && (d[31] != s.a[31]);
        pc_target  = s.pc_target;
        pc_plus4   = s.pc_plus4;
        write_data = s.a ^ 32'hA5A5_0000;
        {rd, reg_write, mem_write, result_src} = ctrlOf(s);
        flush      = s.flush;
        out_ready  = s.out_ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_in_ready = 1'b1;
        m_rv  = 1'b0;
        m_rpc = '0;
        m_brc = '0;
        m_brt = '0;
    endtask

    task automatic modelEdge();
        logic acc, dlv, tk;
        pkt_t p;
        acc = cur.in_valid && m_in_ready && !cur.flush;
        dlv = (q.size() != 0) && cur.out_ready;
        tk  = refTaken(cur);
        m_rv = acc && tk;
        if (m_rv) m_rpc = cur.pc_target;
        if (acc && (cur.branch || cur.jump)) m_brc = m_brc + 1;
        if (acc && tk) m_brt = m_brt + 1;
        if (cur.flush) begin
            q.delete();
        end else begin
            if (dlv) void'(q.pop_front());
            if (acc) begin
                p.alu  = cur.a - cur.b;
                p.wd   = cur.a ^ 32'hA5A5_0000;
                p.pc4  = cur.pc_plus4;
                p.ctrl = ctrlOf(cur);
                q.push_back(p);
            end
        end
        m_in_ready = (q.size() < 2);
    endtask

    task automatic checkAll();
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
        checkOutput("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
        checkOutput("redirect_pc", redirect_pc, m_rpc);
        if (q.size() != 0) begin
            checkOutput("out_alu_result", out_alu_result, q[0].alu);
            checkOutput("out_write_data", out_write_data, q[0].wd);
            checkOutput("out_pc_plus4", out_pc_plus4, q[0].pc4);
            checkOutput("out_ctrl", {22'd0, out_rd, out_reg_write, out_mem_write, out_result_src},
                        {22'd0, q[0].ctrl});
        end
`ifdef BRANCH_STATS_EN
        checkOutput("br_count", br_count, m_brc);
        checkOutput("br_taken_count", br_taken_count, m_brt);
`endif
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    stim_t idle;
    stim_t rs;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'd5,         32'd5,         1'b1};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'd5,         32'd6,         1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'd5,         32'd6,         1'b1};
        vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1,         1'b1};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'd1,         1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b110, 32'd1,         32'd2,         1'b1};
        vecs[7]  = '{1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1,         1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b111, 32'd2,         32'd2,         1'b1};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'd3,         32'd3,         1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'd3,         32'd4,         1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'b010, 32'd3,         32'd4,         1'b1};
        vecs[12] = '{1'b0, 1'b0, 3'b000, 32'd9,         32'd9,         1'b0};

        idle = mkStim(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
        applyStimulus(idle);
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("reset_out_alu_result", out_alu_result, 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
        rst = 1'b1;

        // Taken BEQ right out of reset.
        applyStimulus(mkStim(1'b1, 1'b1, 1'b0, 3'b000, 32'd7, 32'd7, 32'h40, 32'h4, 1'b1, 1'b0));
        stepCycle();
        checkOutput("t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        checkOutput("t1_redirect_pc", redirect_pc, 32'h40);
        checkOutput("t1_out_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(idle);
        stepCycle();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(mkStim(1'b1, vecs[i].branch, vecs[i].jump, vecs[i].funct3,
                                 vecs[i].a, vecs[i].b, 32'h1000 + 32'(i * 4),
                                 32'h2000 + 32'(i * 4), 1'b1, 1'b0));
            stepCycle();
            checkOutput($sformatf("vec%0d_taken", i), {31'd0, redirect_valid},
                        {31'd0, vecs[i].exp_taken});
            applyStimulus(idle);
            stepCycle();
        end

        // Backpressure: two entries queue up, then drain in order.
        applyStimulus(mkStim(1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd0, 32'd0, 32'h8, 1'b0, 1'b0));
        stepCycle();
        checkOutput("t3_in_ready_one", {31'd0, in_ready}, 32'd1);
        applyStimulus(mkStim(1'b1, 1'b0, 1'b0, 3'b000, 32'd6, 32'd0, 32'd0, 32'hC, 1'b0, 1'b0));
        stepCycle();
        checkOutput("t3_in_ready_two", {31'd0, in_ready}, 32'd0);
        checkOutput("t3_first", out_alu_result, 32'd5);
        applyStimulus(idle);
        stepCycle();
        checkOutput("t3_second", out_alu_result, 32'd6);
        checkOutput("t3_second_valid", {31'd0, out_valid}, 32'd1);
        stepCycle();
        checkOutput("t3_drained", {31'd0, out_valid}, 32'd0);

        // Jump ignores funct3 and carries the link value.
        applyStimulus(mkStim(1'b1, 1'b0, 1'b1, 3'b010, 32'd1, 32'd2, 32'h100, 32'h24, 1'b1, 1'b0));
        stepCycle();
        checkOutput("t4_redirect_pc", redirect_pc, 32'h100);
        checkOutput("t4_pc_plus4", out_pc_plus4, 32'h24);
        applyStimulus(idle);
        stepCycle();

        // Flush while full, with a deliver and a taken jump presented on the same edge.
        applyStimulus(mkStim(1'b1, 1'b0, 1'b0, 3'b000, 32'd11, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0));
        stepCycle();
        applyStimulus(mkStim(1'b1, 1'b0, 1'b0, 3'b000, 32'd12, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("t5_full", {31'd0, in_ready}, 32'd0);
        applyStimulus(mkStim(1'b1, 1'b0, 1'b1, 3'b000, 32'd13, 32'd0, 32'h200, 32'h0, 1'b1, 1'b1));
        stepCycle();
        checkOutput("t5_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t5_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("t5_no_redirect", {31'd0, redirect_valid}, 32'd0);
        checkOutput("t5_redirect_pc_held", redirect_pc, 32'h100);
        applyStimulus(idle);
        stepCycle();

        // Asynchronous reset while an entry and a redirect are live.
        applyStimulus(mkStim(1'b1, 1'b0, 1'b1, 3'b000, 32'd20, 32'd1, 32'h300, 32'h0, 1'b0, 1'b0));
        stepCycle();
        checkOutput("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t6_pre_redirect", {31'd0, redirect_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_async_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_async_redirect", {31'd0, redirect_valid}, 32'd0);
        checkOutput("t6_async_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("t6_async_redirect_pc", redirect_pc, 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(idle);
        stepCycle();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(3) == 0) ? a : $urandom;
            rs = mkStim(($urandom_range(3) != 0), 1'($urandom_range(1)),
                        ($urandom_range(5) == 0), 3'($urandom_range(7)), a, b,
                        $urandom, $urandom, ($urandom_range(4) < 3),
                        ($urandom_range(19) == 0));
            applyStimulus(rs);
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory boundary of the 32-bit RISC-V core; sits directly downstream of the ALU and consumes its Result, Carry, Zero, Negative and OverFlow outputs.
- Resolves conditional branches and jumps from the ALU flags and issues a one-cycle PC redirect.
- Registers the instruction's datapath/control into the EX/MEM pipeline slot through a valid/ready handshake with a 2-entry skid buffer, so in_ready is a registered signal.

Parameters:
- XLEN, 32, datapath width (result, write data, PCs).
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  EX holds a valid instruction.
- in_ready  out  1  stage can accept; registered.
- alu_result  in  XLEN  ALU Result.
- carry, zero, negative, overflow  in  1 each  ALU flags for the same instruction.
- branch  in  1  conditional branch instruction.
- jump  in  1  JAL/JALR.
- funct3  in  3  branch condition code.
- pc_target  in  XLEN  precomputed branch/jump target.
- pc_plus4  in  XLEN  link value.
- write_data  in  XLEN  store data (rs2).
- rd  in  RD_W  destination register.
- reg_write, mem_write  in  1 each  control.
- result_src  in  2  writeback mux select.
- flush  in  1  synchronous kill of this stage.
- out_valid  out  1  EX/MEM slot valid.
- out_ready  in  1  MEM stage accepts.
- out_alu_result, out_write_data, out_pc_plus4  out  XLEN  registered copies.
- out_rd  out  RD_W; out_reg_write, out_mem_write  out  1; out_result_src  out  2.
- redirect_valid  out  1  one-cycle pulse: taken branch/jump.
- redirect_pc  out  XLEN  fetch target.

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY, in_ready=1, out_valid=0, redirect_valid=0; all data outputs 0.
- Accept = in_valid & in_ready & ~flush. Deliver = out_valid & out_ready.
- Taken condition, evaluated at accept; the ALU has performed A−B with Carry=1 meaning no borrow:
  - funct3 000 BEQ: zero.
  - 001 BNE: ~zero.
  - 100 BLT: negative^overflow.
  - 101 BGE: ~(negative^overflow).
  - 110 BLTU: ~carry.
  - 111 BGEU: carry.
  - 010/011: never taken.
- taken = jump | (branch & cond). jump has priority; funct3 is ignored when jump=1.
- redirect_valid=1 and redirect_pc=pc_target on the cycle after an accepted taken instruction, independent of out_ready. redirect_valid=0 otherwise; redirect_pc holds its last value.
- Skid FSM:
  - EMPTY: out_valid=0. Accept -> ONE (main reg loaded).
  - ONE: out_valid=1.
    - accept & deliver -> ONE, main reloaded.
    - accept & ~deliver -> TWO, input into skid reg.
    - ~accept & deliver -> EMPTY.
  - TWO: in_ready=0.
    - deliver -> ONE, skid moves to main.
    - otherwise hold.
- in_ready registered = (next_state != TWO).
- Outputs always come from the main reg; order is preserved.
- Flush: next cycle state=EMPTY, both entries invalidated, that cycle's input discarded, no redirect generated. Flush overrides a simultaneous deliver on the same edge.
- Asynchronous reset mid-transfer drops all in-flight entries immediately.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs br_count and br_taken_count (32 bits each).
  - br_count increments on every accepted instruction with branch|jump.
  - br_taken_count increments on every accepted taken one.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then in_valid=1, branch=1, funct3=000, zero=1, pc_target=0x0000_0040 -> next cycle redirect_valid=1, redirect_pc=0x40, out_valid=1.
2. BLT with negative=1, overflow=1 -> not taken, redirect_valid=0. BLTU with carry=0 -> taken.
3. out_ready=0; send 2 instructions, alu_result=0x5 then 0x6 -> in_ready falls to 0 after the second. Raising out_ready delivers 0x5 then 0x6 in order.
4. jump=1, funct3=010, pc_target=0x100, pc_plus4=0x24 -> redirect to 0x100; out_pc_plus4=0x24.
5. FSM in TWO with flush=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no delivery counted.
6. Assert rst=0 mid-cycle with out_valid=1 -> out_valid and redirect_valid drop immediately without a clock edge.
